equilibrium_maxxing_uc: RTL and testbench
=========================================

Name: equilibrium_maxxing_uc

Overview:
Control unit (Moore FSM) for the Equilibrium Maxxing game; sits directly upstream of the datapath (equilibrium_maxxing_fd) and drives all of its control inputs.
- Sequences: idle -> pendulum calibration -> difficulty selection/lock -> preparation delay -> rounds -> end of game.
- Consumes datapath status: end switches, prep_done tick, ganhou_ponto/perdeu_ponto.
- Counts rounds itself and exposes state for 7-seg debug.

Parameters:
ROUNDS, 10, rounds per game; game ends when the round counter reaches this value
PREP_TICKS, 4, number of prep_done pulses spent in PREPARA before the first round
CALIB_TIMEOUT, 500_000_000, clock cycles allowed in CALIBRA before ERRO

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; forces INICIAL and clears all counters
iniciar  in  1  start/confirm button, already debounced, level
end_left  in  1  left end-stop switch
end_right  in  1  right end-stop switch
prep_done  in  1  one-cycle tick from datapath prep counter
ganhou_ponto  in  1  round won (pulse or level)
perdeu_ponto  in  1  round lost (pulse or level)
calib  out  1  pendulum calibration request
start_game  out  1  level latch strobe
reset_nivel_locked  out  1  clears latched difficulty
reset_nivel  out  1  clears score / game counter
reset_prep_cnt  out  1  restarts datapath prep counter
trava_servo  out  1  holds pendulum during preparation
gerar_nova_jogada  out  1  new target LED request
fade_trigger  out  1  LED fade start
conta_nivel  out  1  advance game counter
fim_jogo  out  1  high in FIM
erro  out  1  high in ERRO
rodada  out  8  completed rounds, zero-extended
db_estado  out  4  state encoding below

Behaviour:
- Outputs are pure decode of the state register; every strobe is exactly 1 cycle because its state lasts 1 cycle.
- Reset values: state INICIAL, rodada 0, prep/calib counters 0, iniciar_q 0.
- Outputs in INICIAL: reset_nivel=1, reset_nivel_locked=1; all others 0.
- go = iniciar & ~iniciar_q, where iniciar_q is a registered copy of iniciar. A held button yields one go.

States (db_estado), transitions evaluated each rising edge:
- 0 INICIAL: go -> CALIBRA. Clears rodada.
- 1 CALIBRA: calib=1; calib counter increments.
  - end_left|end_right -> ESCOLHE; the end-stop check has priority over timeout.
  - Otherwise counter == CALIB_TIMEOUT-1 -> ERRO.
- 2 ESCOLHE: go -> TRAVA.
- 3 TRAVA: start_game=1, reset_prep_cnt=1; -> PREPARA.
- 4 PREPARA: trava_servo=1.
  - Prep counter increments on prep_done.
  - prep_done with counter == PREP_TICKS-1 -> GERA; prep counter cleared.
- 5 GERA: gerar_nova_jogada=1; -> FADE.
- 6 FADE: fade_trigger=1, reset_prep_cnt=1; -> JOGANDO.
- 7 JOGANDO: ganhou_ponto -> PONTO; else perdeu_ponto -> ERROU. Both high: ganhou wins.
- 8 PONTO: conta_nivel=1; rodada+1; -> FIM if new rodada == ROUNDS, else GERA.
- 9 ERROU: rodada+1; same exit rule as PONTO.
- 10 FIM: fim_jogo=1; go -> INICIAL.
- 11 ERRO: erro=1; go -> INICIAL.
- Unused encodings (12-15): next state INICIAL.

Counters and timing:
- rodada saturates at ROUNDS.
- Calib counter is cleared whenever state != CALIBRA; prep counter whenever state != PREPARA.
- Counter widths: $clog2 of (max value + 1).
- Latency from a won round to the next gerar_nova_jogada: 2 cycles (JOGANDO->PONTO->GERA).
- Reset asserted in any state: next edge returns to INICIAL, counters 0, all strobes deasserted; the reset_nivel decode holds as in INICIAL.

Optional Feature:
EQM_UC_LIVES_EN (macro).
- Enabled:
  - Adds parameter LIVES (default 3) and output vidas [3:0].
  - vidas resets to LIVES and reloads on INICIAL.
  - ERROU decrements vidas; ERROU with vidas == 1 -> FIM regardless of rodada.
- Disabled: no vidas port; losses only advance rodada.

Test Plan:
- Bench parameters: ROUNDS=3, PREP_TICKS=2, CALIB_TIMEOUT=100.
- Reset, then pulse iniciar, raise end_left at cycle 10 of CALIBRA -> db_estado 0->1->2; calib high exactly while in state 1.
- Hold iniciar high 50 cycles in ESCOLHE -> exactly one start_game pulse; after 2 prep_done ticks -> exactly one gerar_nova_jogada, then fade_trigger on the next cycle.
- Three rounds: ganhou, perdeu, ganhou -> conta_nivel pulses 2 times; rodada 1,2,3; fim_jogo=1 with db_estado=10 after the third round.
- No end switch in CALIBRA -> ERRO entered after exactly 100 cycles, erro=1; go -> INICIAL.
- ganhou_ponto and perdeu_ponto high on the same cycle -> PONTO taken. Reset asserted in JOGANDO -> next cycle db_estado=0, rodada=0.
- EQM_UC_LIVES_EN, LIVES=2, ROUNDS=10: two perdeu_ponto -> FIM with rodada=2, vidas=0.

Source files
------------

// File: rtl/equilibrium_maxxing_uc.sv
// Moore control unit for the Equilibrium Maxxing game: sequences calibration, difficulty lock,
// preparation and rounds. Optional lives counter is enabled by defining EQM_UC_LIVES_EN.
module equilibrium_maxxing_uc #(
  parameter int ROUNDS        = 10,
  parameter int PREP_TICKS    = 4,
  parameter int CALIB_TIMEOUT = 500_000_000
`ifdef EQM_UC_LIVES_EN
  , parameter int LIVES       = 3
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       end_left,
  input  logic       end_right,
  input  logic       prep_done,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  output logic       calib,
  output logic       start_game,
  output logic       reset_nivel_locked,
  output logic       reset_nivel,
  output logic       reset_prep_cnt,
  output logic       trava_servo,
  output logic       gerar_nova_jogada,
  output logic       fade_trigger,
  output logic       conta_nivel,
  output logic       fim_jogo,
  output logic       erro,
  output logic [7:0] rodada,
  output logic [3:0] db_estado
`ifdef EQM_UC_LIVES_EN
  ,
  output logic [3:0] vidas
`endif
);

  localparam logic [3:0] INICIAL = 4'd0;
  localparam logic [3:0] CALIBRA = 4'd1;
  localparam logic [3:0] ESCOLHE = 4'd2;
  localparam logic [3:0] TRAVA   = 4'd3;
  localparam logic [3:0] PREPARA = 4'd4;
  localparam logic [3:0] GERA    = 4'd5;
  localparam logic [3:0] FADE    = 4'd6;
  localparam logic [3:0] JOGANDO = 4'd7;
  localparam logic [3:0] PONTO   = 4'd8;
  localparam logic [3:0] ERROU   = 4'd9;
  localparam logic [3:0] FIM     = 4'd10;
  localparam logic [3:0] ERRO    = 4'd11;

  localparam int CW = (CALIB_TIMEOUT > 1) ? $clog2(CALIB_TIMEOUT) : 1;
  localparam int PW = (PREP_TICKS > 1) ? $clog2(PREP_TICKS) : 1;
  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_TIMEOUT - 1);
  localparam logic [PW-1:0] PREP_LAST  = PW'(PREP_TICKS - 1);
  localparam logic [RW-1:0] ROUNDS_W   = RW'(ROUNDS);

  logic [3:0]    state, state_d;
  logic          iniciar_q;
  logic          go;
  logic [CW-1:0] calib_cnt;
  logic [PW-1:0] prep_cnt;
  logic [RW-1:0] rodada_q, rodada_inc;
  logic          last_round;

  assign go         = iniciar & ~iniciar_q;
  assign rodada_inc = (rodada_q == ROUNDS_W) ? rodada_q : rodada_q + 1'b1;
  assign last_round = (rodada_inc == ROUNDS_W);

  always_comb begin
    state_d = state;
    case (state)
      INICIAL: if (go) state_d = CALIBRA;
      // end-stop hit beats a timeout landing on the same cycle
      CALIBRA: if (end_left | end_right)      state_d = ESCOLHE;
               else if (calib_cnt == CALIB_LAST) state_d = ERRO;
      ESCOLHE: if (go) state_d = TRAVA;
      TRAVA:   state_d = PREPARA;
      PREPARA: if (prep_done && prep_cnt == PREP_LAST) state_d = GERA;
      GERA:    state_d = FADE;
      FADE:    state_d = JOGANDO;
      JOGANDO: if (ganhou_ponto)      state_d = PONTO;
               else if (perdeu_ponto) state_d = ERROU;
      PONTO:   state_d = last_round ? FIM : GERA;
`ifdef EQM_UC_LIVES_EN
      ERROU:   state_d = (last_round || vidas == 4'd1) ? FIM : GERA;
`else
      ERROU:   state_d = last_round ? FIM : GERA;
`endif
      FIM:     if (go) state_d = INICIAL;
      ERRO:    if (go) state_d = INICIAL;
      default: state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INICIAL;
      iniciar_q <= 1'b0;
      calib_cnt <= '0;
      prep_cnt  <= '0;
      rodada_q  <= '0;
    end else begin
      state     <= state_d;
      iniciar_q <= iniciar;
      calib_cnt <= (state == CALIBRA) ? calib_cnt + 1'b1 : '0;
      if (state != PREPARA)
        prep_cnt <= '0;
      else if (prep_done)
        prep_cnt <= (prep_cnt == PREP_LAST) ? '0 : prep_cnt + 1'b1;
      if (state == INICIAL)
        rodada_q <= '0;
      else if (state == PONTO || state == ERROU)
        rodada_q <= rodada_inc;
    end
  end

`ifdef EQM_UC_LIVES_EN
  always_ff @(posedge clock) begin
    if (reset || state == INICIAL)
      vidas <= 4'(LIVES);
    else if (state == ERROU && vidas != 4'd0)
      vidas <= vidas - 4'd1;
  end
`endif

  assign calib              = (state == CALIBRA);
  assign start_game         = (state == TRAVA);
  assign reset_nivel_locked = (state == INICIAL);
  assign reset_nivel        = (state == INICIAL);
  assign reset_prep_cnt     = (state == TRAVA) || (state == FADE);
  assign trava_servo        = (state == PREPARA);
  assign gerar_nova_jogada  = (state == GERA);
  assign fade_trigger       = (state == FADE);
  assign conta_nivel        = (state == PONTO);
  assign fim_jogo           = (state == FIM);
  assign erro               = (state == ERRO);
  assign rodada             = 8'(rodada_q);
  assign db_estado          = state;

endmodule

// File: tb/tb_equilibrium_maxxing_uc.sv
// Directed bench for equilibrium_maxxing_uc (ROUNDS=3, PREP_TICKS=2, CALIB_TIMEOUT=100);
// lives scenario runs on a second instance when EQM_UC_LIVES_EN is defined.
module tb_equilibrium_maxxing_uc;
  logic clock = 1'b0;
  logic reset, iniciar, end_left, end_right, prep_done, ganhou_ponto, perdeu_ponto;
  logic calib, start_game, reset_nivel_locked, reset_nivel, reset_prep_cnt, trava_servo;
  logic gerar_nova_jogada, fade_trigger, conta_nivel, fim_jogo, erro;
  logic [7:0] rodada;
  logic [3:0] db_estado;
  logic [10:0] strobes;
  logic [10:0] exp_str [12];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] in;   // {iniciar,end_left,end_right,prep_done,ganhou,perdeu,reset}
    int         st;
    int         rod;
  } vec_t;
  vec_t vt[$];

  always #5 clock = ~clock;

  equilibrium_maxxing_uc #(.ROUNDS(3), .PREP_TICKS(2), .CALIB_TIMEOUT(100)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .end_left(end_left),
    .end_right(end_right), .prep_done(prep_done), .ganhou_ponto(ganhou_ponto),
    .perdeu_ponto(perdeu_ponto), .calib(calib), .start_game(start_game),
    .reset_nivel_locked(reset_nivel_locked), .reset_nivel(reset_nivel),
    .reset_prep_cnt(reset_prep_cnt), .trava_servo(trava_servo),
    .gerar_nova_jogada(gerar_nova_jogada), .fade_trigger(fade_trigger),
    .conta_nivel(conta_nivel), .fim_jogo(fim_jogo), .erro(erro),
    .rodada(rodada), .db_estado(db_estado)
`ifdef EQM_UC_LIVES_EN
    , .vidas(vidas)
`endif
  );

  assign strobes = {calib, start_game, reset_nivel_locked, reset_nivel, reset_prep_cnt,
                    trava_servo, gerar_nova_jogada, fade_trigger, conta_nivel, fim_jogo, erro};

`ifdef EQM_UC_LIVES_EN
  logic [3:0] vidas;
  logic l_reset, l_ini, l_el, l_er, l_pd, l_gan, l_per;
  logic l_calib, l_sg, l_rnl, l_rn, l_rpc, l_trava, l_gera, l_fade, l_conta, l_fim, l_erro;
  logic [7:0] l_rodada;
  logic [3:0] l_estado, l_vidas;

  equilibrium_maxxing_uc #(.ROUNDS(10), .PREP_TICKS(2), .CALIB_TIMEOUT(100), .LIVES(2)) dut_l (
    .clock(clock), .reset(l_reset), .iniciar(l_ini), .end_left(l_el), .end_right(l_er),
    .prep_done(l_pd), .ganhou_ponto(l_gan), .perdeu_ponto(l_per), .calib(l_calib),
    .start_game(l_sg), .reset_nivel_locked(l_rnl), .reset_nivel(l_rn),
    .reset_prep_cnt(l_rpc), .trava_servo(l_trava), .gerar_nova_jogada(l_gera),
    .fade_trigger(l_fade), .conta_nivel(l_conta), .fim_jogo(l_fim), .erro(l_erro),
    .rodada(l_rodada), .db_estado(l_estado), .vidas(l_vidas)
  );

  task automatic ldrive(input logic [6:0] b);
    {l_ini, l_el, l_er, l_pd, l_gan, l_per, l_reset} = b;
  endtask
`endif

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input int st, input int rod);
    chk({nm, " state"}, int'(db_estado), st);
    chk({nm, " rodada"}, int'(rodada), rod);
    chk({nm, " strobes"}, int'(strobes), int'(exp_str[st]));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [6:0] b);
    {iniciar, end_left, end_right, prep_done, ganhou_ponto, perdeu_ponto, reset} = b;
  endtask

  task automatic add(input logic [6:0] b, input int st, input int rod);
    vec_t v;
    v.in = b; v.st = st; v.rod = rod;
    vt.push_back(v);
  endtask

  initial begin
    int n, conta_cnt, split;
    // strobe order: calib,start,rnl,rn,rpc,trava,gera,fade,conta,fim,erro
    exp_str[0]  = 11'b00110000000;
    exp_str[1]  = 11'b10000000000;
    exp_str[2]  = 11'b00000000000;
    exp_str[3]  = 11'b01001000000;
    exp_str[4]  = 11'b00000100000;
    exp_str[5]  = 11'b00000010000;
    exp_str[6]  = 11'b00001001000;
    exp_str[7]  = 11'b00000000000;
    exp_str[8]  = 11'b00000000100;
    exp_str[9]  = 11'b00000000000;
    exp_str[10] = 11'b00000000010;
    exp_str[11] = 11'b00000000001;

    // three rounds from JOGANDO: won, lost, won
    add(7'b0000100, 8, 0);  add(7'b0000000, 5, 1);  add(7'b0000000, 6, 1);
    add(7'b0000000, 7, 1);  add(7'b0000010, 9, 1);  add(7'b0000000, 5, 2);
    add(7'b0000000, 6, 2);  add(7'b0000000, 7, 2);  add(7'b0000100, 8, 2);
    add(7'b0000000, 10, 3); add(7'b0000000, 10, 3); add(7'b1000000, 0, 3);
    add(7'b0000000, 0, 0);
    split = vt.size();
    // second game: end_right, back-to-back prep ticks, both results high, reset in JOGANDO
    add(7'b1000000, 1, 0);  add(7'b0010000, 2, 0);  add(7'b1000000, 3, 0);
    add(7'b0000000, 4, 0);  add(7'b0001000, 4, 0);  add(7'b0001000, 5, 0);
    add(7'b0000000, 6, 0);  add(7'b0000000, 7, 0);  add(7'b0000110, 8, 0);
    add(7'b0000000, 5, 1);  add(7'b0000000, 6, 1);  add(7'b0000000, 7, 1);
    add(7'b0000001, 0, 0);  add(7'b0000000, 0, 0);

`ifdef EQM_UC_LIVES_EN
    ldrive(7'b0000001);
`endif
    drive(7'b0000001); step; chk_state("reset", 0, 0);
    drive(7'b1000000); step; chk_state("go", 1, 0);
    drive(7'b0000000);
    for (int i = 1; i < 10; i++) begin step; chk_state("calib", 1, 0); end
    drive(7'b0100000); step; chk_state("end_left", 2, 0);

    drive(7'b1000000); n = 0;
    for (int i = 0; i < 50; i++) begin
      step;
      if (start_game) n++;
      if (i == 0) chk_state("trava", 3, 0);
    end
    chk("start_game pulses", n, 1);
    chk_state("prep hold", 4, 0);

    drive(7'b0001000); step; chk_state("prep tick1", 4, 0);
    drive(7'b0000000); step; chk_state("prep gap", 4, 0);
    drive(7'b0001000); step; chk_state("gera", 5, 0);
    drive(7'b0000000); step; chk_state("fade", 6, 0);
    step; chk_state("jogando", 7, 0);

    conta_cnt = 0;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].in);
      step;
      if (i < split && conta_nivel) conta_cnt++;
      chk_state($sformatf("vec%0d", i), vt[i].st, vt[i].rod);
    end
    chk("conta_nivel pulses", conta_cnt, 2);

    // calibration timeout: 100 cycles in CALIBRA, then ERRO
    drive(7'b1000000); step; chk_state("to go", 1, 0);
    drive(7'b0000000); n = 0;
    for (int i = 1; i < 100; i++) begin step; if (db_estado == 4'd1) n++; end
    chk("calib cycles", n, 99);
    step; chk_state("erro", 11, 0);
    step; chk_state("erro hold", 11, 0);
    drive(7'b1000000); step; chk_state("erro exit", 0, 0);
    drive(7'b0000000); step;

`ifdef EQM_UC_LIVES_EN
    begin
      logic [6:0] lin [14];
      int         lst [14];
      lin = '{7'b0000000, 7'b1000000, 7'b0100000, 7'b1000000, 7'b0000000, 7'b0001000,
              7'b0001000, 7'b0000000, 7'b0000000, 7'b0000010, 7'b0000000, 7'b0000000,
              7'b0000000, 7'b0000010};
      lst = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 9, 5, 6, 7, 9};
      for (int i = 0; i < 14; i++) begin
        ldrive(lin[i]); step;
        chk($sformatf("lives vec%0d state", i), int'(l_estado), lst[i]);
        if (i == 0) chk("lives reset vidas", int'(l_vidas), 2);
        if (i == 10) chk("lives after loss", int'(l_vidas), 1);
      end
      ldrive(7'b0000000); step;
      chk("lives fim state", int'(l_estado), 10);
      chk("lives rodada", int'(l_rodada), 2);
      chk("lives vidas", int'(l_vidas), 0);
      chk("lives fim_jogo", int'(l_fim), 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
